// File: rtl/layer_batch_sequencer.sv
// Layer/batch scheduler for the transpose-convolution core: issues start pulses once
// ifmap/weight dependencies are met, with output-BRAM clear, abort and run watchdog.
module layer_batch_sequencer #(
    parameter int NUM_LAYERS      = 4,
    parameter int LAYER_W         = 2,
    parameter int BATCH_W         = 4,
    parameter logic [NUM_LAYERS*BATCH_W-1:0] BATCH_LAST = {4'd0, 4'd0, 4'd3, 4'd7},
    parameter int CLEAR_CYCLES    = 2,
    parameter int WEIGHT_PREFETCH = 1,
    parameter int WRAP_LAYERS     = 1,
    parameter int TIMEOUT_CYCLES  = 0,
    parameter int TIMEOUT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               weight_write_done,
    input  logic               ifmap_write_done,
    input  logic               batch_complete,
    input  logic               ext_abort,
    output logic               start_pulse,
    output logic [BATCH_W-1:0] current_batch_id,
    output logic [LAYER_W-1:0] current_layer_id,
    output logic               layer_transition,
    output logic               clear_output_bram,
    output logic               all_batches_complete,
    output logic               busy,
    output logic               weight_ready,
    output logic               ifmap_ready,
    output logic               timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ISSUE, S_RUN, S_WAIT_W, S_LAYER_DONE, S_FINISHED
    } state_t;

    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CLR_W-1:0]     CLR_LAST   = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [LAYER_W-1:0]   LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
    localparam logic                 TO_EN      = (TIMEOUT_CYCLES > 0);
    localparam logic [TIMEOUT_W-1:0] TO_LAST    = TO_EN ? TIMEOUT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t               state, state_nx;
    logic                 weight_prev, ifmap_prev;
    logic                 weight_loaded, ifmap_loaded;
    logic [CLR_W-1:0]     clr_cnt;
    logic [TIMEOUT_W-1:0] wd_cnt;
    logic [BATCH_W-1:0]   batch_last_cur;
    logic                 w_edge, i_edge, w_accept, bc_eff, clr_done;
    logic                 idle_exit, layer_exit, wait_exit;

    assign w_edge = weight_write_done & ~weight_prev;
    assign i_edge = ifmap_write_done & ~ifmap_prev;
    // Without prefetch, a weight set arriving while a batch is being issued/run is lost.
    assign w_accept = w_edge & ~ext_abort &
                      ((WEIGHT_PREFETCH != 0) || !(state == S_ISSUE || state == S_RUN));
    // The first cycle of RUN carries the start pulse; a completion there is stale.
    assign bc_eff   = batch_complete & (state == S_RUN) & ~start_pulse;
    assign clr_done = (clr_cnt == CLR_LAST);

    assign idle_exit  = (state == S_IDLE)       && (state_nx == S_ISSUE);
    assign layer_exit = (state == S_LAYER_DONE) && (state_nx == S_CLEAR);
    assign wait_exit  = (state == S_WAIT_W)     && (state_nx == S_ISSUE);

    always_comb begin
        batch_last_cur = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (current_layer_id == LAYER_W'(i))
                batch_last_cur = BATCH_LAST[i*BATCH_W +: BATCH_W];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:       if (weight_loaded && ifmap_loaded) state_nx = S_ISSUE;
            S_CLEAR:      if (clr_done) state_nx = S_ISSUE;
            S_ISSUE:      state_nx = S_RUN;
            S_RUN: begin
                if (bc_eff) begin
                    if (current_batch_id == batch_last_cur) begin
                        if (current_layer_id == LAST_LAYER && WRAP_LAYERS == 0)
                            state_nx = S_FINISHED;
                        else
                            state_nx = S_LAYER_DONE;
                    end else begin
                        state_nx = S_WAIT_W;
                    end
                end
            end
            S_WAIT_W:     if (weight_loaded) state_nx = S_ISSUE;
            S_LAYER_DONE: if (weight_loaded && ifmap_loaded) state_nx = S_CLEAR;
            S_FINISHED:   state_nx = S_FINISHED;
            default:      state_nx = S_IDLE;
        endcase
        if (ext_abort) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            weight_prev      <= 1'b0;
            ifmap_prev       <= 1'b0;
            weight_loaded    <= 1'b0;
            ifmap_loaded     <= 1'b0;
            start_pulse      <= 1'b0;
            layer_transition <= 1'b0;
            current_batch_id <= '0;
            current_layer_id <= '0;
            clr_cnt          <= '0;
            wd_cnt           <= '0;
            timeout_err      <= 1'b0;
        end else begin
            state            <= state_nx;
            weight_prev      <= weight_write_done;
            ifmap_prev       <= ifmap_write_done;
            start_pulse      <= (state == S_ISSUE) && !ext_abort;
            layer_transition <= layer_exit;

            if (ext_abort) begin
                weight_loaded    <= 1'b0;
                ifmap_loaded     <= 1'b0;
                current_batch_id <= '0;
                current_layer_id <= '0;
                clr_cnt          <= '0;
                wd_cnt           <= '0;
                timeout_err      <= 1'b0;
            end else begin
                // A set landing on the consume/clear cycle wins: it is the next set.
                if (w_accept)               weight_loaded <= 1'b1;
                else if (state == S_ISSUE)  weight_loaded <= 1'b0;

                if (i_edge)                       ifmap_loaded <= 1'b1;
                else if (idle_exit || layer_exit) ifmap_loaded <= 1'b0;

                if (idle_exit) begin
                    current_batch_id <= '0;
                    current_layer_id <= '0;
                end else if (wait_exit) begin
                    current_batch_id <= current_batch_id + BATCH_W'(1);
                end else if (layer_exit) begin
                    current_batch_id <= '0;
                    current_layer_id <= (current_layer_id == LAST_LAYER) ? '0
                                        : current_layer_id + LAYER_W'(1);
                end

                if (state == S_CLEAR && !clr_done) clr_cnt <= clr_cnt + CLR_W'(1);
                else                               clr_cnt <= '0;

                if (state == S_ISSUE)
                    wd_cnt <= '0;
                else if (state == S_RUN && wd_cnt != '1)
                    wd_cnt <= wd_cnt + TIMEOUT_W'(1);

                if (TO_EN && state == S_RUN && wd_cnt == TO_LAST)
                    timeout_err <= 1'b1;
            end
        end
    end

    assign clear_output_bram    = (state == S_CLEAR);
    assign all_batches_complete = (state == S_LAYER_DONE) || (state == S_FINISHED);
    assign busy                 = !((state == S_IDLE) || (state == S_FINISHED));
    assign weight_ready         = weight_loaded;
    assign ifmap_ready          = ifmap_loaded;

endmodule

// File: tb/tb_layer_batch_sequencer.sv
// Bench for layer_batch_sequencer: directed vectors; expected start pulses
// (cycle, layer, batch) go into queues and a negedge monitor checks them.
module tb_layer_batch_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // dut_a: prefetch on, no wrap, watchdog 10; dut_b: prefetch off
    logic       a_w = 0, a_i = 0, a_bc = 0, a_ab = 0;
    logic       a_start, a_lt, a_clr, a_abc, a_busy, a_wr, a_ir, a_to;
    logic [3:0] a_batch;
    logic [1:0] a_layer;
    logic       b_w = 0, b_i = 0, b_bc = 0, b_ab = 0;
    logic       b_start, b_lt, b_clr, b_abc, b_busy, b_wr, b_ir, b_to;
    logic [3:0] b_batch;
    logic [1:0] b_layer;

    logic [31:0] exp_a_q[$];
    logic [31:0] exp_b_q[$];
    logic [31:0] ea, eb;

    layer_batch_sequencer #(
        .WEIGHT_PREFETCH(1), .WRAP_LAYERS(0), .TIMEOUT_CYCLES(10)
    ) dut_a (
        .clk(clk), .rst(rst),
        .weight_write_done(a_w), .ifmap_write_done(a_i),
        .batch_complete(a_bc), .ext_abort(a_ab),
        .start_pulse(a_start), .current_batch_id(a_batch), .current_layer_id(a_layer),
        .layer_transition(a_lt), .clear_output_bram(a_clr),
        .all_batches_complete(a_abc), .busy(a_busy),
        .weight_ready(a_wr), .ifmap_ready(a_ir), .timeout_err(a_to)
    );

    layer_batch_sequencer #(
        .WEIGHT_PREFETCH(0)
    ) dut_b (
        .clk(clk), .rst(rst),
        .weight_write_done(b_w), .ifmap_write_done(b_i),
        .batch_complete(b_bc), .ext_abort(b_ab),
        .start_pulse(b_start), .current_batch_id(b_batch), .current_layer_id(b_layer),
        .layer_transition(b_lt), .clear_output_bram(b_clr),
        .all_batches_complete(b_abc), .busy(b_busy),
        .weight_ready(b_wr), .ifmap_ready(b_ir), .timeout_err(b_to)
    );

    function automatic logic [31:0] pk(input int c, input logic [1:0] l, input logic [3:0] b);
        logic [31:0] cv;
        cv = c;
        return {cv[25:0], l, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // start-pulse scoreboard: each start must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && a_start) begin
            checks++;
            if (exp_a_q.size() == 0) begin
                errors++;
                $display("FAIL a_start_unexpected: got start cyc %0d L%0d B%0d, expected none",
                         cyc, a_layer, a_batch);
            end else begin
                ea = exp_a_q.pop_front();
                if (pk(cyc, a_layer, a_batch) !== ea) begin
                    errors++;
                    $display("FAIL a_start: got cyc %0d L%0d B%0d, expected cyc %0d L%0d B%0d",
                             cyc, a_layer, a_batch, ea[31:6], ea[5:4], ea[3:0]);
                end
            end
        end
        if (!rst && b_start) begin
            checks++;
            if (exp_b_q.size() == 0) begin
                errors++;
                $display("FAIL b_start_unexpected: got start cyc %0d L%0d B%0d, expected none",
                         cyc, b_layer, b_batch);
            end else begin
                eb = exp_b_q.pop_front();
                if (pk(cyc, b_layer, b_batch) !== eb) begin
                    errors++;
                    $display("FAIL b_start: got cyc %0d L%0d B%0d, expected cyc %0d L%0d B%0d",
                             cyc, b_layer, b_batch, eb[31:6], eb[5:4], eb[3:0]);
                end
            end
        end
    end

    // Called in a LAYER_DONE cycle; returns in the ISSUE cycle of layer nl.
    task automatic a_enter_layer(input int nl, input bit need_w);
        int d;
        tick();
        d = cyc;
        a_i = 1;
        if (need_w) a_w = 1;
        exp_a_q.push_back(pk(d + 5, 2'(nl), 4'd0));
        tick();
        a_i = 0; a_w = 0;
        chk("enter_d1_lt", 32'(a_lt), 0);
        chk("enter_d1_clr", 32'(a_clr), 0);
        chk("enter_d1_abc", 32'(a_abc), 1);
        tick();
        chk("enter_d2_lt", 32'(a_lt), 1);
        chk("enter_d2_clr", 32'(a_clr), 1);
        chk("enter_d2_layer", 32'(a_layer), 32'(nl));
        chk("enter_d2_batch", 32'(a_batch), 0);
        chk("enter_d2_abc", 32'(a_abc), 0);
        tick();
        chk("enter_d3_lt", 32'(a_lt), 0);
        chk("enter_d3_clr", 32'(a_clr), 1);
        tick();
        chk("enter_d4_clr", 32'(a_clr), 0);
        chk("enter_d4_busy", 32'(a_busy), 1);
    endtask

    initial begin
        int t, s, c;
        // reset: everything low
        tick(); tick();
        chk("rst_a_outputs", 32'({a_start, a_batch, a_layer, a_lt, a_clr, a_abc, a_busy,
                                  a_wr, a_ir, a_to}), 0);
        chk("rst_b_outputs", 32'({b_start, b_batch, b_layer, b_lt, b_clr, b_abc, b_busy,
                                  b_wr, b_ir, b_to}), 0);
        rst = 0;
        tick();

        // first start: both edges at t -> start at t+3
        t = cyc;
        a_i = 1; a_w = 1;
        exp_a_q.push_back(pk(t + 3, 2'd0, 4'd0));
        tick();
        a_i = 0; a_w = 0;
        chk("t1_wr", 32'(a_wr), 1);
        chk("t1_ir", 32'(a_ir), 1);
        chk("t1_busy", 32'(a_busy), 0);
        tick();
        chk("t2_busy", 32'(a_busy), 1);
        chk("t2_ir_consumed", 32'(a_ir), 0);
        tick();
        chk("t3_clr", 32'(a_clr), 0);

        // layer 0: batches 1..7 each need a weight edge after completion
        for (int b = 0; b < 7; b++) begin
            tick(); tick();
            c = cyc;
            a_bc = 1;
            exp_a_q.push_back(pk(c + 4, 2'd0, 4'(b + 1)));
            tick();
            a_bc = 0; a_w = 1;
            chk("l0_wait_batch", 32'(a_batch), 32'(b));
            chk("l0_wait_abc", 32'(a_abc), 0);
            tick();
            a_w = 0;
            tick();
            chk("l0_issue_batch", 32'(a_batch), 32'(b + 1));
            tick();
        end
        tick(); tick();
        a_bc = 1;
        tick();
        a_bc = 0;
        chk("l0_done_abc", 32'(a_abc), 1);
        chk("l0_done_busy", 32'(a_busy), 1);
        chk("l0_done_batch", 32'(a_batch), 7);

        // layer 1: weight prefetched mid-RUN -> start 3 cycles after completion
        a_enter_layer(1, 1);
        tick();
        for (int b = 0; b < 3; b++) begin
            if (b == 0) a_bc = 1;
            tick();
            a_bc = 0; a_w = 1;
            tick();
            a_w = 0;
            chk("l1_prefetch_wr", 32'(a_wr), 1);
            tick();
            c = cyc;
            a_bc = 1;
            exp_a_q.push_back(pk(c + 3, 2'd1, 4'(b + 1)));
            tick();
            a_bc = 0;
            tick(); tick();
        end
        tick(); tick();
        a_bc = 1;
        tick();
        a_bc = 0;
        chk("l1_done_abc", 32'(a_abc), 1);

        // layer 2: weight edge on the ISSUE cycle survives the consume
        a_enter_layer(2, 1);
        a_w = 1;
        tick();
        a_w = 0;
        chk("l2_set_on_consume_wr", 32'(a_wr), 1);
        tick(); tick();
        a_bc = 1;
        tick();
        a_bc = 0;
        chk("l2_done_abc", 32'(a_abc), 1);
        chk("l2_done_wr", 32'(a_wr), 1);

        // layer 3 is the last; no wrap -> FINISHED
        a_enter_layer(3, 0);
        tick(); tick(); tick();
        a_bc = 1;
        tick();
        a_bc = 0;
        chk("fin_busy", 32'(a_busy), 0);
        chk("fin_abc", 32'(a_abc), 1);
        chk("fin_layer", 32'(a_layer), 3);
        a_i = 1; a_w = 1;
        tick();
        a_i = 0; a_w = 0;
        tick(); tick(); tick(); tick();
        chk("fin_hold_busy", 32'(a_busy), 0);
        chk("fin_hold_abc", 32'(a_abc), 1);
        a_ab = 1;
        tick();
        a_ab = 0;
        chk("abort_fin_state", 32'({a_busy, a_abc}), 0);
        chk("abort_fin_ids", 32'({a_layer, a_batch}), 0);
        chk("abort_fin_flags", 32'({a_wr, a_ir, a_to}), 0);

        // watchdog: no completion, error after 10 RUN cycles
        t = cyc;
        a_i = 1; a_w = 1;
        exp_a_q.push_back(pk(t + 3, 2'd0, 4'd0));
        tick();
        a_i = 0; a_w = 0;
        tick(); tick();
        s = cyc;
        chk("wd_start_to", 32'(a_to), 0);
        while (cyc < s + 9) tick();
        chk("wd_9_to", 32'(a_to), 0);
        tick();
        chk("wd_10_to", 32'(a_to), 1);
        tick(); tick();
        chk("wd_sticky_to", 32'(a_to), 1);
        chk("wd_busy", 32'(a_busy), 1);
        a_ab = 1;
        tick();
        a_ab = 0;
        chk("wd_abort_to", 32'(a_to), 0);
        chk("wd_abort_busy", 32'(a_busy), 0);

        // abort during ISSUE: no start, coincident ifmap edge dropped
        a_i = 1; a_w = 1;
        tick();
        a_i = 0; a_w = 0;
        tick();
        chk("ab_issue_busy", 32'(a_busy), 1);
        a_ab = 1; a_i = 1;
        tick();
        a_ab = 0; a_i = 0;
        chk("ab_issue_idle", 32'(a_busy), 0);
        chk("ab_issue_flags", 32'({a_wr, a_ir}), 0);
        tick(); tick(); tick();

        // dut_b: no prefetch -> weight edge during RUN lost, waits for a new one
        t = cyc;
        b_i = 1; b_w = 1;
        exp_b_q.push_back(pk(t + 3, 2'd0, 4'd0));
        tick();
        b_i = 0; b_w = 0;
        tick(); tick();
        s = cyc;
        tick();
        b_w = 1;
        tick();
        b_w = 0;
        chk("b_run_edge_dropped", 32'(b_wr), 0);
        tick();
        b_bc = 1;
        tick();
        b_bc = 0;
        tick(); tick(); tick();
        chk("b_stuck_busy", 32'(b_busy), 1);
        chk("b_stuck_wr", 32'(b_wr), 0);
        b_w = 1;
        exp_b_q.push_back(pk(s + 10, 2'd0, 4'd1));
        tick();
        b_w = 0;
        chk("b_wait_wr", 32'(b_wr), 1);
        repeat (6) tick();

        chk("a_queue_drained", 32'(exp_a_q.size()), 0);
        chk("b_queue_drained", 32'(exp_b_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/layer_batch_sequencer.md
Name: layer_batch_sequencer

Overview:
Parametrised next-generation batch/layer scheduler for the transpose-convolution accelerator. Sequences NUM_LAYERS layers, each with a per-layer batch count. Issues one-cycle start pulses to the compute core once data dependencies are met:
- Layer entry needs both a fresh ifmap and a weight set.
- Subsequent batches in the same layer reuse the ifmap and need only a new weight set.
Adds weight prefetch, a timed output-BRAM clear phase that gates the first start of a layer, an abort path, a run watchdog and a non-wrapping finish mode.

Parameters:
NUM_LAYERS, 4, number of layers sequenced (>=1)
LAYER_W, 2, width of layer id (>= clog2(NUM_LAYERS), min 1)
BATCH_W, 4, width of batch id
BATCH_LAST, {4'd0,4'd0,4'd3,4'd7}, packed NUM_LAYERS*BATCH_W; field i = last batch index of layer i
CLEAR_CYCLES, 2, clear_output_bram pulse length (>=1)
WEIGHT_PREFETCH, 1, 1 = weight-done edges are latched while a batch runs
WRAP_LAYERS, 1, 1 = after last layer wrap to layer 0; 0 = stop in FINISHED
TIMEOUT_CYCLES, 0, RUN watchdog limit; 0 = disabled
TIMEOUT_W, 16, watchdog counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
weight_write_done  in  1  level; rising edge = one weight set loaded
ifmap_write_done  in  1  level; rising edge = one ifmap loaded
batch_complete  in  1  pulse from compute core
ext_abort  in  1  synchronous abort to IDLE
start_pulse  out  1  registered one-cycle start to compute core
current_batch_id  out  BATCH_W  batch in progress
current_layer_id  out  LAYER_W  layer in progress
layer_transition  out  1  one-cycle pulse on layer advance
clear_output_bram  out  1  high for CLEAR_CYCLES cycles after a layer advance
all_batches_complete  out  1  high in LAYER_DONE or FINISHED
busy  out  1  state not IDLE and not FINISHED
weight_ready  out  1  weight_loaded flag
ifmap_ready  out  1  ifmap_loaded flag
timeout_err  out  1  sticky watchdog error

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high on rst. While rst is high, every output and every flag is 0, and the state is IDLE.
- Edge detect: registered previous value of each done input; rising edge = in & ~prev.
- weight_loaded:
  - Set on a weight edge.
  - Cleared when leaving ISSUE (consumed).
  - If a set and the consume fall in the same cycle, the flag stays 1 (prefetched set).
  - WEIGHT_PREFETCH=0: weight edges in ISSUE or RUN are dropped.
- ifmap_loaded:
  - Set on an ifmap edge.
  - Cleared only on layer entry (IDLE->ISSUE, LAYER_DONE->CLEAR).
  - If a set and the clear fall in the same cycle, the flag stays 1.
- States: IDLE, CLEAR, ISSUE, RUN, WAIT_W, LAYER_DONE, FINISHED.
- IDLE:
  - Exit when weight_loaded & ifmap_loaded.
  - Go to ISSUE with batch_id=0 and layer_id=0; no clear phase.
- ISSUE: one cycle, then RUN. start_pulse is high the cycle after ISSUE, which is the first RUN cycle.
- RUN:
  - batch_complete is ignored in the cycle start_pulse is high, and in every state other than RUN.
  - On batch_complete with batch_id == BATCH_LAST[layer_id]:
    - last layer with WRAP_LAYERS=0 -> FINISHED;
    - otherwise -> LAYER_DONE.
  - On batch_complete otherwise -> WAIT_W.
- WAIT_W: when weight_loaded -> ISSUE, batch_id+1 on that edge.
- LAYER_DONE:
  - Exit when both flags are set -> CLEAR.
  - On that edge: layer_id+1 (wraps NUM_LAYERS-1 -> 0), batch_id=0, layer_transition=1 for the next cycle.
- CLEAR: clear_output_bram held high for exactly CLEAR_CYCLES cycles, then ISSUE. No start is issued while clear is high.
- FINISHED: held until rst or ext_abort.
- Timing: flag-ready in cycle t (state IDLE) -> state ISSUE at t+1 -> start_pulse at t+2. Latency from WAIT_W is identical.
- Watchdog:
  - Counter resets on entry to RUN and counts each RUN cycle.
  - When it reaches TIMEOUT_CYCLES (nonzero), timeout_err sets and stays set.
  - The state is unaffected; cleared only by rst or ext_abort.
- ext_abort:
  - Highest priority, from any state: next cycle state=IDLE; ids, flags, clear counter, watchdog and timeout_err = 0.
  - No start_pulse is issued; a start_pulse already registered this cycle still completes.
  - Done edges coincident with the abort are dropped.
- Ids are never modified outside the transitions listed above.

Test Plan:
- Reset, then ifmap edge and weight edge in the same cycle t -> start_pulse at t+3 (flags set at t+1), batch=0, layer=0; no clear_output_bram.
- Layer 0 (BATCH_LAST=7): 8 batch_complete pulses, each followed by a weight edge -> 8 start pulses with batch 0..7; all_batches_complete rises after the 8th; no ifmap edge needed after the first.
- From LAYER_DONE with both edges -> layer_transition 1 cycle, layer 0->1, clear_output_bram high 2 cycles, start_pulse exactly 1 cycle after clear falls.
- WEIGHT_PREFETCH=1: weight edge mid-RUN, then batch_complete -> next start 3 cycles after batch_complete with no further edge. With WEIGHT_PREFETCH=0 the same stimulus -> stuck in WAIT_W until a new edge.
- WRAP_LAYERS=0, layer 3 last batch completes -> FINISHED, busy=0, all_batches_complete=1, further edges ignored; ext_abort -> IDLE, ids 0.
- TIMEOUT_CYCLES=10, no batch_complete -> timeout_err rises after 10 RUN cycles and stays high; ext_abort mid-RUN clears it and issues no start.
